// File: rtl/i2s_codec_phy_pkg.sv
// Shared I2S definitions for the codec PHY, the AXI-stream controller and the bench.
package i2s_pkg;

  localparam int unsigned I2S_D_WIDTH       = 24;
  localparam int unsigned I2S_SLOT_WIDTH    = 32;
  localparam int unsigned I2S_BCLK_HALF_DIV = 4;

  typedef enum logic {
    WS_LEFT  = 1'b0,
    WS_RIGHT = 1'b1
  } ws_e;

  // Audio bits occupy slot positions 1..d_width; position 0 is the one-bclk I2S delay.
  function automatic logic is_data_bit(int unsigned slot_bit, int unsigned d_width);
    return (slot_bit >= 1) && (slot_bit <= d_width);
  endfunction

endpackage

// File: rtl/i2s_codec_phy_if.sv
// Codec serial pins plus the parallel sample words exchanged with the controller.
interface i2s_codec_phy_if #(
  parameter int unsigned D_WIDTH = i2s_pkg::I2S_D_WIDTH
);
  logic               bclk;
  logic               ws;
  logic               sdata_out;
  logic               sdata_in;
  logic [D_WIDTH-1:0] l_data_rx;
  logic [D_WIDTH-1:0] r_data_rx;
  logic [D_WIDTH-1:0] l_data_tx;
  logic [D_WIDTH-1:0] r_data_tx;

  modport master (
    output bclk, ws, sdata_out, l_data_rx, r_data_rx,
    input  sdata_in, l_data_tx, r_data_tx
  );

  modport slave (
    input  bclk, ws, sdata_out, l_data_rx, r_data_rx,
    output sdata_in, l_data_tx, r_data_tx
  );
endinterface

// File: rtl/i2s_codec_phy_bclk_gen.sv
// Divides aclk into the registered bit clock and flags its rising/falling transitions.
module i2s_bclk_gen
  import i2s_pkg::*;
#(
  parameter int unsigned BCLK_HALF_DIV = I2S_BCLK_HALF_DIV
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic en,
  output logic bclk,
  output logic rise,
  output logic fall
);

  localparam int unsigned DIV_W = (BCLK_HALF_DIV > 1) ? $clog2(BCLK_HALF_DIV) : 1;

  logic [DIV_W-1:0] div_cnt;
  logic             wrap;

  // Strobes are valid in the cycle before the edge that registers the new bclk level.
  always_comb begin
    wrap = en && (div_cnt == DIV_W'(BCLK_HALF_DIV - 1));
    rise = wrap && !bclk;
    fall = wrap && bclk;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (!en) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (wrap) begin
      div_cnt <= '0;
      bclk    <= ~bclk;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/i2s_codec_phy.sv
// I2S master PHY: frame counting, word select, DAC shift-out and ADC shift-in on aclk.
module i2s_codec_phy
  import i2s_pkg::*;
#(
  parameter int unsigned D_WIDTH       = I2S_D_WIDTH,
  parameter int unsigned SLOT_WIDTH    = I2S_SLOT_WIDTH,
  parameter int unsigned BCLK_HALF_DIV = I2S_BCLK_HALF_DIV
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             en,
  i2s_codec_phy_if.master  bus
);

  localparam int unsigned FRAME_BITS = 2 * SLOT_WIDTH;
  localparam int unsigned BIT_W      = $clog2(FRAME_BITS);

  logic               bclk;
  logic               rise;
  logic               fall;
  logic [BIT_W-1:0]   bit_cnt;
  logic [BIT_W-1:0]   bit_cnt_nxt;
  int unsigned        slot_bit_cur;
  int unsigned        slot_bit_nxt;
  ws_e                ws_q;
  ws_e                ws_nxt;
  logic               load_left;
  logic               load_right;
  logic               sample_bit;
  logic               emit_bit;
  logic               sdata_q;
  logic [D_WIDTH-1:0] tx_shift;
  logic [D_WIDTH-1:0] rx_shift;
  logic [D_WIDTH-1:0] l_rx_q;
  logic [D_WIDTH-1:0] r_rx_q;

  i2s_bclk_gen #(
    .BCLK_HALF_DIV (BCLK_HALF_DIV)
  ) u_bclk_gen (
    .aclk    (aclk),
    .aresetn (aresetn),
    .en      (en),
    .bclk    (bclk),
    .rise    (rise),
    .fall    (fall)
  );

  // Everything keyed to a fall looks at the bit_cnt value being entered, not the one left.
  always_comb begin
    bit_cnt_nxt  = (bit_cnt == BIT_W'(FRAME_BITS - 1)) ? '0 : bit_cnt + BIT_W'(1);
    slot_bit_cur = 32'(bit_cnt) % SLOT_WIDTH;
    slot_bit_nxt = 32'(bit_cnt_nxt) % SLOT_WIDTH;
    ws_nxt       = (32'(bit_cnt_nxt) >= SLOT_WIDTH) ? WS_RIGHT : WS_LEFT;
    load_left    = fall && (bit_cnt_nxt == '0);
    load_right   = fall && (bit_cnt_nxt == BIT_W'(SLOT_WIDTH));
    sample_bit   = rise && is_data_bit(slot_bit_cur, D_WIDTH);
    emit_bit     = is_data_bit(slot_bit_nxt, D_WIDTH);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      bit_cnt <= '0;
      ws_q    <= WS_LEFT;
    end else if (!en) begin
      bit_cnt <= '0;
      ws_q    <= WS_LEFT;
    end else if (fall) begin
      bit_cnt <= bit_cnt_nxt;
      ws_q    <= ws_nxt;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tx_shift <= '0;
      sdata_q  <= 1'b0;
    end else if (!en) begin
      tx_shift <= '0;
      sdata_q  <= 1'b0;
    end else if (load_left) begin
      tx_shift <= bus.l_data_tx;
      sdata_q  <= 1'b0;
    end else if (load_right) begin
      tx_shift <= bus.r_data_tx;
      sdata_q  <= 1'b0;
    end else if (fall) begin
      if (emit_bit) begin
        sdata_q  <= tx_shift[D_WIDTH-1];
        tx_shift <= {tx_shift[D_WIDTH-2:0], 1'b0};
      end else begin
        sdata_q  <= 1'b0;
      end
    end
  end

  // Words are published on the ws edge so they stay stable for the whole next slot.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rx_shift <= '0;
      l_rx_q   <= '0;
      r_rx_q   <= '0;
    end else if (!en) begin
      rx_shift <= '0;
    end else begin
      if (sample_bit) begin
        rx_shift <= {rx_shift[D_WIDTH-2:0], bus.sdata_in};
      end
      if (load_right) begin
        l_rx_q <= rx_shift;
      end
      if (load_left) begin
        r_rx_q <= rx_shift;
      end
    end
  end

  assign bus.bclk      = bclk;
  assign bus.ws        = ws_q;
  assign bus.sdata_out = sdata_q;
  assign bus.l_data_rx = l_rx_q;
  assign bus.r_data_rx = r_rx_q;

endmodule

// File: tb/tb_i2s_codec_phy.sv
// Loopback scoreboard bench for i2s_codec_phy: ws events and transmitted slot words are checked against queued expectations.
module tb_i2s_codec_phy;
  import i2s_pkg::*;

  localparam int unsigned DW = I2S_D_WIDTH;
  localparam int unsigned SW = I2S_SLOT_WIDTH;
  localparam int unsigned HD = I2S_BCLK_HALF_DIV;

  logic          aclk    = 1'b0;
  logic          aresetn = 1'b0;
  logic          en      = 1'b0;
  logic [DW-1:0] l_tx    = '0;
  logic [DW-1:0] r_tx    = '0;

  i2s_codec_phy_if #(.D_WIDTH(DW)) bus ();

  assign bus.sdata_in  = bus.sdata_out;
  assign bus.l_data_tx = l_tx;
  assign bus.r_data_tx = r_tx;

  i2s_codec_phy #(
    .D_WIDTH       (DW),
    .SLOT_WIDTH    (SW),
    .BCLK_HALF_DIV (HD)
  ) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .en      (en),
    .bus     (bus)
  );

  always #5 aclk = ~aclk;

  // cyc == n at the negedge following the n-th enabled posedge since the last restart
  int unsigned cyc = 0;
  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn || !en) cyc <= 0;
    else                 cyc <= cyc + 1;
  end

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
  endtask

  typedef struct {
    int unsigned   at;
    logic          ws;
    logic [DW-1:0] l;
    logic [DW-1:0] r;
  } ws_exp_t;

  ws_exp_t       wsq[$];
  logic [DW-1:0] txq[$];

  task automatic push_ws(input int unsigned at, input logic ws, input logic [DW-1:0] l, input logic [DW-1:0] r);
    ws_exp_t e;
    e.at = at; e.ws = ws; e.l = l; e.r = r;
    wsq.push_back(e);
  endtask

  // Monitor: consumes expectations at every ws edge, assembles each slot's serial word.
  int unsigned   tog_cnt = 0, last_tog = 0, k = 0;
  logic [DW-1:0] word = '0, hold_l = '0, hold_r = '0, exp_w;
  logic          junk = 1'b0, ws_prev = 1'b0, bclk_prev = 1'b0, fell;
  ws_exp_t       e;

  always @(negedge aclk) begin
    if (!aresetn || !en) begin
      if (aresetn) begin
        check("l_rx_hold_while_disabled", bus.l_data_rx, hold_l);
        check("r_rx_hold_while_disabled", bus.r_data_rx, hold_r);
      end else begin
        hold_l = '0;
        hold_r = '0;
      end
      ws_prev = 1'b0; bclk_prev = 1'b0; k = 0; word = '0; junk = 1'b0;
      tog_cnt = 0; last_tog = 0;
    end else begin
      fell = (bclk_prev === 1'b1) && (bus.bclk === 1'b0);
      if (bus.bclk !== bclk_prev) begin
        if (tog_cnt == 0)      check("first_bclk_rise_cyc", cyc, HD);
        else if (tog_cnt == 1) check("first_bclk_fall_cyc", cyc, 2 * HD);
        else                   check("bclk_half_period", cyc - last_tog, HD);
        last_tog  = cyc;
        tog_cnt++;
        bclk_prev = bus.bclk;
      end
      if (bus.ws !== ws_prev) begin
        check("ws_edge_on_bclk_fall", fell, 1);
        if (wsq.size() == 0) check("ws_event_expected", wsq.size(), 1);
        else begin
          e = wsq.pop_front();
          check("ws_edge_cyc", cyc, e.at);
          check("ws_value", bus.ws, e.ws);
          check("l_data_rx", bus.l_data_rx, e.l);
          check("r_data_rx", bus.r_data_rx, e.r);
          hold_l = e.l;
          hold_r = e.r;
        end
        if (txq.size() == 0) check("tx_slot_expected", txq.size(), 1);
        else begin
          exp_w = txq.pop_front();
          check("tx_slot_word", word, exp_w);
          check("tx_slot_zero_fill", junk, 0);
        end
        k = 0; word = '0; junk = bus.sdata_out;
        ws_prev = bus.ws;
      end else begin
        check("l_rx_stable", bus.l_data_rx, hold_l);
        check("r_rx_stable", bus.r_data_rx, hold_r);
        if (fell) begin
          k++;
          if (k >= 1 && k <= DW) word = {word[DW-2:0], bus.sdata_out};
          else                   junk = junk | bus.sdata_out;
        end
      end
    end
  end

  task automatic wait_cyc(input int unsigned n);
    int unsigned b = 0;
    do begin
      @(negedge aclk);
      b++;
    end while (cyc != n && b < 5000);
    check("wait_cyc_reached", cyc, n);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_bclk"}, bus.bclk, 0);
    check({tag, "_ws"}, bus.ws, 0);
    check({tag, "_sdata_out"}, bus.sdata_out, 0);
    check({tag, "_l_data_rx"}, bus.l_data_rx, 0);
    check({tag, "_r_data_rx"}, bus.r_data_rx, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete (cyc %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Run 1: loopback, frame timing, bit mapping, tx sampling point
    en   = 1'b1;
    l_tx = 24'hA5A5A5;
    r_tx = 24'h123456;
    repeat (3) @(negedge aclk);
    check_outputs_zero("reset");

    push_ws(256,  1'b1, 24'h000000, 24'h000000);
    push_ws(512,  1'b0, 24'h000000, 24'h123456);
    push_ws(768,  1'b1, 24'hA5A5A5, 24'h123456);
    push_ws(1024, 1'b0, 24'hA5A5A5, 24'h123456);
    push_ws(1280, 1'b1, 24'h111111, 24'h123456);
    push_ws(1536, 1'b0, 24'h111111, 24'h800001);
    push_ws(1792, 1'b1, 24'h222222, 24'h800001);
    push_ws(2048, 1'b0, 24'h222222, 24'h800001);
    push_ws(2304, 1'b1, 24'h222222, 24'h800001);
    txq = '{24'h000000, 24'h123456, 24'hA5A5A5, 24'h123456,
            24'h111111, 24'h800001, 24'h222222, 24'h800001, 24'h222222};

    #1 aresetn = 1'b1;
    wait_cyc(900);  #1 l_tx = 24'h111111;
    wait_cyc(1024); #1 l_tx = 24'h222222;
    wait_cyc(1200); #1 r_tx = 24'h800001;

    // Asynchronous reset in the middle of a right slot
    wait_cyc(2400);
    check("run1_ws_queue_drained", wsq.size(), 0);
    check("run1_tx_queue_drained", txq.size(), 0);
    #1 aresetn = 1'b0;
    #1 check_outputs_zero("async_reset");

    // Run 2: restart after reset, then an en gap mid right slot
    l_tx = 24'h3C3C3C;
    r_tx = 24'h0F0F0F;
    push_ws(256, 1'b1, 24'h000000, 24'h000000);
    push_ws(512, 1'b0, 24'h000000, 24'h0F0F0F);
    push_ws(768, 1'b1, 24'h3C3C3C, 24'h0F0F0F);
    txq = '{24'h000000, 24'h0F0F0F, 24'h3C3C3C};
    @(negedge aclk);
    #1 aresetn = 1'b1;

    wait_cyc(812);
    #1 en = 1'b0;
    repeat (5) @(negedge aclk);
    check("gap_bclk", bus.bclk, 0);
    check("gap_ws", bus.ws, 0);
    check("gap_sdata_out", bus.sdata_out, 0);
    repeat (90) @(negedge aclk);
    check("gap_late_bclk", bus.bclk, 0);
    check("gap_late_ws", bus.ws, 0);
    check("gap_late_sdata_out", bus.sdata_out, 0);
    check("run2_ws_queue_drained", wsq.size(), 0);
    check("run2_tx_queue_drained", txq.size(), 0);

    push_ws(256, 1'b1, 24'h000000, 24'h0F0F0F);
    push_ws(512, 1'b0, 24'h000000, 24'h0F0F0F);
    push_ws(768, 1'b1, 24'h3C3C3C, 24'h0F0F0F);
    txq = '{24'h000000, 24'h0F0F0F, 24'h3C3C3C};
    #1 en = 1'b1;

    wait_cyc(800);
    check("run3_ws_queue_drained", wsq.size(), 0);
    check("run3_tx_queue_drained", txq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
